// File: rtl/sq_accum_pkg.sv
// Shared definitions for the sq_accum block: FSM state encoding,
// default configuration values and the sample counter width helper.
package sq_accum_pkg;

  // Run-control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Default number of squares summed per run.
  localparam int N_SAMPLES_DEF = 8;

  // Default accumulator / sum width in bits.
  localparam int ACC_W_DEF = 11;

  // Width of a counter that must hold values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sq_sat_add.sv
// Saturating adder: accumulator plus a zero-extended 8-bit sample.
// On overflow the result clips to all-ones and ovf_o is raised.
module sq_sat_add
  import sq_accum_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [7:0]       add_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             ovf_o
);

  logic [ACC_W:0] wide_s;

  assign wide_s = {1'b0, acc_i} + {{(ACC_W - 7){1'b0}}, add_i};

  // Clip the widened sum to the accumulator range.
  always_comb begin
    ovf_o = wide_s[ACC_W];
    if (wide_s[ACC_W]) begin
      sum_o = '1;
    end else begin
      sum_o = wide_s[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/sq_accum.sv
// Sum-of-squares accumulator. Collects N_SAMPLES squares from an upstream
// valid/ready source, saturating at ACC_W bits, then presents the result
// with a valid/ready handshake. Optional feature macro SQ_ACCUM_MAX_EN adds
// max_out, the largest sample accepted in the current run.
module sq_accum
  import sq_accum_pkg::*;
#(
  parameter int N_SAMPLES = N_SAMPLES_DEF,
  parameter int ACC_W     = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       sq_in,
  input  logic             sq_valid,
  output logic             sq_ready,
  output logic [ACC_W-1:0] sum_out,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             sat,
  output logic             busy
`ifdef SQ_ACCUM_MAX_EN
  ,
  output logic [7:0]       max_out
`endif
);

  localparam int CW = cnt_width(N_SAMPLES);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc_s;
  logic             last_s;
  logic [ACC_W-1:0] add_sum_s;
  logic             add_ovf_s;
`ifdef SQ_ACCUM_MAX_EN
  logic [7:0]       max_q, max_d;
`endif

  sq_sat_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .acc_i (acc_q),
    .add_i (sq_in),
    .sum_o (add_sum_s),
    .ovf_o (add_ovf_s)
  );

  assign cnt_inc_s = cnt_q + CW'(1);
  assign last_s    = (cnt_inc_s == CW'(N_SAMPLES));

  // Next-state logic: abort overrides everything, otherwise the run FSM.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    cnt_d   = cnt_q;
`ifdef SQ_ACCUM_MAX_EN
    max_d   = max_q;
`endif
    if (abort) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
`ifdef SQ_ACCUM_MAX_EN
      max_d   = 8'd0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_RUN;
            acc_d   = '0;
            sat_d   = 1'b0;
            cnt_d   = '0;
`ifdef SQ_ACCUM_MAX_EN
            max_d   = 8'd0;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (sq_valid) begin
            acc_d = add_sum_s;
            cnt_d = cnt_inc_s;
            if (add_ovf_s) begin
              sat_d = 1'b1;
            end else begin
              sat_d = sat_q;
            end
`ifdef SQ_ACCUM_MAX_EN
            if (sq_in > max_q) begin
              max_d = sq_in;
            end else begin
              max_d = max_q;
            end
`endif
            if (last_s) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          if (sum_ready) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, accumulator, saturation flag and sample count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SQ_ACCUM_MAX_EN
  // Largest sample accepted in the current run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= 8'd0;
    end else begin
      max_q <= max_d;
    end
  end

  assign max_out = max_q;
`endif

  assign sq_ready  = (state_q == ST_RUN);
  assign sum_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign sum_out   = acc_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_sq_accum.sv
// Self-checking bench for sq_accum. Three instances with different
// N_SAMPLES / ACC_W settings share clock and reset. Checks: reset state,
// a table-driven run, directed corner sequences and randomized runs against
// an arithmetic reference model. Define SQ_ACCUM_MAX_EN to also check max_out.
module tb_sq_accum;

  localparam int NI = 3;
  localparam int NS [NI] = '{4, 2, 3};
  localparam int AW [NI] = '{11, 8, 11};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NI-1:0] start_i, abort_i, sqv_i, sumr_i;
  logic [7:0]    sq_i [NI];
  logic [NI-1:0] rdy_o, sv_o, sat_o, busy_o;
  logic [10:0]   sum0, sum2;
  logic [7:0]    sum1;
  logic [15:0]   sum_o [NI];
`ifdef SQ_ACCUM_MAX_EN
  logic [7:0]    max_o [NI];
`endif

  int checks = 0;
  int errors = 0;

  // reference model state per instance
  int m_ph  [NI];
  int m_acc [NI];
  int m_sat [NI];
  int m_cnt [NI];
  int m_max [NI];

  assign sum_o[0] = {5'd0, sum0};
  assign sum_o[1] = {8'd0, sum1};
  assign sum_o[2] = {5'd0, sum2};

  always #5 clk = ~clk;

  sq_accum #(.N_SAMPLES(4), .ACC_W(11)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_i[0]), .abort(abort_i[0]),
    .sq_in(sq_i[0]), .sq_valid(sqv_i[0]), .sq_ready(rdy_o[0]),
    .sum_out(sum0), .sum_valid(sv_o[0]), .sum_ready(sumr_i[0]),
    .sat(sat_o[0]), .busy(busy_o[0])
`ifdef SQ_ACCUM_MAX_EN
    , .max_out(max_o[0])
`endif
  );

  sq_accum #(.N_SAMPLES(2), .ACC_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_i[1]), .abort(abort_i[1]),
    .sq_in(sq_i[1]), .sq_valid(sqv_i[1]), .sq_ready(rdy_o[1]),
    .sum_out(sum1), .sum_valid(sv_o[1]), .sum_ready(sumr_i[1]),
    .sat(sat_o[1]), .busy(busy_o[1])
`ifdef SQ_ACCUM_MAX_EN
    , .max_out(max_o[1])
`endif
  );

  sq_accum #(.N_SAMPLES(3), .ACC_W(11)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_i[2]), .abort(abort_i[2]),
    .sq_in(sq_i[2]), .sq_valid(sqv_i[2]), .sq_ready(rdy_o[2]),
    .sum_out(sum2), .sum_valid(sv_o[2]), .sum_ready(sumr_i[2]),
    .sat(sat_o[2]), .busy(busy_o[2])
`ifdef SQ_ACCUM_MAX_EN
    , .max_out(max_o[2])
`endif
  );

  typedef struct {
    logic       st;
    logic       ab;
    logic       v;
    logic [7:0] d;
    logic       sr;
    logic       e_rdy;
    logic       e_sv;
    int         e_sum;
    logic       e_sat;
    logic       e_busy;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_in();
    start_i = '0;
    abort_i = '0;
    sqv_i   = '0;
    sumr_i  = '0;
    for (int k = 0; k < NI; k++) sq_i[k] = 8'd0;
  endtask

  task automatic chk_all(input string nm, input int k, input int e_rdy, input int e_sv,
                         input int e_sum, input int e_sat, input int e_busy);
    chk({nm, " sq_ready"},  32'(rdy_o[k]),  e_rdy);
    chk({nm, " sum_valid"}, 32'(sv_o[k]),   e_sv);
    chk({nm, " sum_out"},   32'(sum_o[k]),  e_sum);
    chk({nm, " sat"},       32'(sat_o[k]),  e_sat);
    chk({nm, " busy"},      32'(busy_o[k]), e_busy);
  endtask

  task automatic drive(input int k, input logic st, input logic v, input logic [7:0] d,
                       input logic sr, input logic ab);
    start_i[k] = st;
    sqv_i[k]   = v;
    sq_i[k]    = d;
    sumr_i[k]  = sr;
    abort_i[k] = ab;
  endtask

  task automatic m_reset(input int k);
    m_ph[k] = 0; m_acc[k] = 0; m_sat[k] = 0; m_cnt[k] = 0; m_max[k] = 0;
  endtask

  // phase 0 = idle, 1 = collecting, 2 = result presented
  task automatic m_step(input int k);
    int lim;
    int s;
    lim = (1 << AW[k]) - 1;
    if (abort_i[k]) begin
      m_ph[k] = 0; m_acc[k] = 0; m_cnt[k] = 0; m_max[k] = 0;
    end else if (m_ph[k] == 0) begin
      if (start_i[k]) begin
        m_ph[k] = 1; m_acc[k] = 0; m_sat[k] = 0; m_cnt[k] = 0; m_max[k] = 0;
      end
    end else if (m_ph[k] == 1) begin
      if (sqv_i[k]) begin
        s = m_acc[k] + int'(sq_i[k]);
        if (s > lim) begin
          m_acc[k] = lim;
          m_sat[k] = 1;
        end else begin
          m_acc[k] = s;
        end
        if (int'(sq_i[k]) > m_max[k]) m_max[k] = int'(sq_i[k]);
        m_cnt[k]++;
        if (m_cnt[k] == NS[k]) m_ph[k] = 2;
      end
    end else begin
      if (sumr_i[k]) m_ph[k] = 0;
    end
  endtask

  task automatic rand_run(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      drive(k, 1'($urandom % 2), 1'($urandom_range(0, 9) < 7), 8'($urandom % 256),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 49) == 0));
      m_step(k);
      cyc();
      chk_all("rnd", k, int'(m_ph[k] == 1), int'(m_ph[k] == 2), m_acc[k], m_sat[k],
              int'(m_ph[k] != 0));
`ifdef SQ_ACCUM_MAX_EN
      chk("rnd max_out", 32'(max_o[k]), m_max[k]);
`endif
    end
    idle_in();
  endtask

  initial begin
    idle_in();
    // table: instance 0 (N=4), samples 1,4,9,16, ignored start/valid outside RUN
    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0, 0,  1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 8'd1,  1'b0, 1'b1, 1'b0, 1,  1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 8'd4,  1'b0, 1'b1, 1'b0, 5,  1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 8'd9,  1'b0, 1'b1, 1'b0, 14, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 8'd16, 1'b0, 1'b0, 1'b1, 30, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 8'd50, 1'b0, 1'b0, 1'b1, 30, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 30, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 8'd5,  1'b0, 1'b0, 1'b0, 30, 1'b0, 1'b0};

    // reset state
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) chk_all("reset", k, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    cyc();
    for (int k = 0; k < NI; k++) chk_all("post-reset", k, 0, 0, 0, 0, 0);

    // randomized runs against the reference model
    for (int k = 0; k < NI; k++) begin
      m_reset(k);
      rand_run(k, 300);
    end
    abort_i = '1;
    cyc();
    idle_in();

    // table-driven run
    for (int i = 0; i < 8; i++) begin
      drive(0, tbl[i].st, tbl[i].v, tbl[i].d, tbl[i].sr, tbl[i].ab);
      cyc();
      chk_all($sformatf("tbl[%0d]", i), 0, int'(tbl[i].e_rdy), int'(tbl[i].e_sv),
              tbl[i].e_sum, int'(tbl[i].e_sat), int'(tbl[i].e_busy));
    end
    idle_in();

    // saturation: N=2, ACC_W=8, 200 + 100 clips to 255
    drive(1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0); cyc();
    drive(1, 1'b0, 1'b1, 8'd200, 1'b0, 1'b0); cyc();
    chk_all("sat first", 1, 1, 0, 200, 0, 1);
    drive(1, 1'b0, 1'b1, 8'd100, 1'b0, 1'b0); cyc();
    chk_all("sat final", 1, 0, 1, 255, 1, 1);
    drive(1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0); cyc();
    chk("sat idle busy", 32'(busy_o[1]), 0);
    // abort beats start in IDLE
    drive(1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1); cyc();
    chk("abort vs start busy", 32'(busy_o[1]), 0);
    chk("abort vs start sum", 32'(sum_o[1]), 0);
    idle_in();

    // gapped valid: N=3, 49,x,64,x,36 -> 149 after exactly three transfers
    drive(2, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0); cyc();
    drive(2, 1'b0, 1'b1, 8'd49,  1'b0, 1'b0); cyc(); chk_all("gap1", 2, 1, 0, 49, 0, 1);
    drive(2, 1'b0, 1'b0, 8'd77,  1'b0, 1'b0); cyc(); chk_all("gap2", 2, 1, 0, 49, 0, 1);
    drive(2, 1'b0, 1'b1, 8'd64,  1'b0, 1'b0); cyc(); chk_all("gap3", 2, 1, 0, 113, 0, 1);
    drive(2, 1'b0, 1'b0, 8'd200, 1'b0, 1'b0); cyc(); chk_all("gap4", 2, 1, 0, 113, 0, 1);
    drive(2, 1'b0, 1'b1, 8'd36,  1'b0, 1'b0); cyc(); chk_all("gap5", 2, 0, 1, 149, 0, 1);
    drive(2, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0); cyc();
    idle_in();

    // DONE hold: sum_ready low for 5 cycles, then high
    drive(0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0); cyc();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b0, 1'b1, 8'd7, 1'b0, 1'b0); cyc();
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0); cyc();
      chk("hold sum_out", 32'(sum_o[0]), 28);
      chk("hold sum_valid", 32'(sv_o[0]), 1);
    end
    drive(0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0); cyc();
    chk("hold release busy", 32'(busy_o[0]), 0);
    chk("hold release sum_valid", 32'(sv_o[0]), 0);
    idle_in();

    // abort with sq_valid after 2 of 4 samples, then a clean run of 4x1
    drive(0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0); cyc();
    drive(0, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0); cyc(); chk("abort pre1 sum_valid", 32'(sv_o[0]), 0);
    drive(0, 1'b0, 1'b1, 8'd5, 1'b0, 1'b0); cyc(); chk("abort pre2 sum_out", 32'(sum_o[0]), 8);
    drive(0, 1'b0, 1'b1, 8'd50, 1'b0, 1'b1); cyc();
    chk_all("abort", 0, 0, 0, 0, 0, 0);
    drive(0, 1'b0, 1'b1, 8'd9, 1'b0, 1'b0); cyc();
    chk("abort after sum_valid", 32'(sv_o[0]), 0);
    drive(0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0); cyc();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0); cyc();
    end
    chk_all("after abort run", 0, 0, 1, 4, 0, 1);
    drive(0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0); cyc();
    idle_in();

`ifdef SQ_ACCUM_MAX_EN
    // max tracking: 9,81,25 -> 81, held in DONE
    drive(2, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0); cyc();
    drive(2, 1'b0, 1'b1, 8'd9,  1'b0, 1'b0); cyc();
    drive(2, 1'b0, 1'b1, 8'd81, 1'b0, 1'b0); cyc();
    drive(2, 1'b0, 1'b1, 8'd25, 1'b0, 1'b0); cyc();
    chk("max done", 32'(max_o[2]), 81);
    chk("max done sum", 32'(sum_o[2]), 115);
    drive(2, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0); cyc();
    chk("max held", 32'(max_o[2]), 81);
    drive(2, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1); cyc();
    chk("max abort", 32'(max_o[2]), 0);
    idle_in();
`endif

    // saturated result on u1 so reset has a sat flag to clear
    drive(1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0); cyc();
    drive(1, 1'b0, 1'b1, 8'd255, 1'b0, 1'b0); cyc();
    drive(1, 1'b0, 1'b1, 8'd255, 1'b0, 1'b0); cyc();
    chk("pre-reset sat", 32'(sat_o[1]), 1);
    idle_in();

    // reset pulsed mid-run: outputs drop between clock edges
    drive(0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0); cyc();
    drive(0, 1'b0, 1'b1, 8'd20, 1'b0, 1'b0); cyc();
    drive(0, 1'b0, 1'b1, 8'd30, 1'b0, 1'b0); cyc();
    chk("pre-reset sum", 32'(sum_o[0]), 50);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) chk_all("async reset", k, 0, 0, 0, 0, 0);
`ifdef SQ_ACCUM_MAX_EN
    for (int k = 0; k < NI; k++) chk("async reset max", 32'(max_o[k]), 0);
`endif
    @(negedge clk);
    chk_all("reset held", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    drive(0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0); cyc();
    chk("first edge after reset busy", 32'(busy_o[0]), 1);
    drive(0, 1'b0, 1'b1, 8'd6, 1'b0, 1'b0); cyc();
    chk("first sample after reset", 32'(sum_o[0]), 6);
    drive(0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1); cyc();
    idle_in();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sq_accum.md
SQ_ACCUM -- requirements
Module: sq_accum

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter N_SAMPLES, default 8, SHALL set the number of squares summed per run (legal 1..255).
REQ-003 Parameter ACC_W, default 11, SHALL set the accumulator and sum width in bits (legal 8..16).
REQ-004 Port clk, input, 1, SHALL be the rising-edge clock.
REQ-005 Port rst_n, input, 1, SHALL be the async active-low reset.
REQ-006 Port start, input, 1, SHALL request a new run; it is sampled in IDLE only.
REQ-007 Port abort, input, 1, SHALL be a synchronous abandon of the current run.
REQ-008 Port sq_in, input, 8, SHALL be the unsigned square value from the upstream square ROM.
REQ-009 Port sq_valid, input, 1, SHALL indicate that sq_in holds a valid sample.
REQ-010 Port sq_ready, output, 1, SHALL indicate that the block accepts a sample this cycle.
REQ-011 Port sum_out, output, ACC_W, SHALL carry the accumulated sum of squares.
REQ-012 Port sum_valid, output, 1, SHALL indicate that sum_out is final.
REQ-013 Port sum_ready, input, 1, SHALL be the consumer acknowledge for sum_out.
REQ-014 Port sat, output, 1, SHALL be high when the sum clipped during the run.
REQ-015 Port busy, output, 1, SHALL be high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-017 IDLE SHALL move to RUN when start is 1, clearing the accumulator, sat and sample count on that edge.
REQ-018 sq_ready SHALL be 1 only in RUN, and a transfer SHALL occur on any edge where sq_valid and sq_ready are both 1.
REQ-019 Each transfer SHALL add zero-extended sq_in to the accumulator and increment the count.
REQ-020 If the addition exceeds 2^ACC_W-1, the accumulator SHALL hold all-ones and sat SHALL set, remaining set until the next start.
REQ-021 On the transfer that makes the count equal N_SAMPLES, the FSM SHALL enter DONE and sum_valid SHALL be 1 on the next cycle (latency 1 cycle after the final transfer).
REQ-022 In DONE, sum_out and sat SHALL be held stable; the FSM SHALL return to IDLE on the edge where sum_ready is 1.
REQ-023 A start asserted in RUN or DONE SHALL be ignored.
REQ-024 sq_valid asserted outside RUN SHALL be ignored, with no transfer.
REQ-025 abort SHALL force IDLE from any state on the next edge, zero sum_out, and drop sum_valid; abort SHALL win over start, a transfer or sum_ready in the same cycle.
REQ-026 sum_out SHALL show the running accumulator in RUN, and sum_valid SHALL be 0 outside DONE.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, zero the accumulator and count, and set sq_ready, sum_valid, sat and busy to 0, including mid-run.
REQ-028 The first state change after reset release SHALL be on the first rising edge where rst_n is 1.

Configuration
REQ-029 With macro SQ_ACCUM_MAX_EN defined, the block SHALL add output max_out (8 bits), tracking the largest sq_in transferred in the run; it SHALL be cleared at start, abort and reset and held in DONE.
REQ-030 Without SQ_ACCUM_MAX_EN, the max_out port and its register SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (IDLE=0, RUN=1, DONE=2), the default N_SAMPLES and ACC_W values, and the count width function.
REQ-032 Saturating addition SHALL be a sub-module named sq_sat_add, parameterised by ACC_W; the FSM, count and handshake logic SHALL stay in sq_accum.

Verification
REQ-033 The bench SHALL check this case: N_SAMPLES=4, start, then samples 1,4,9,16 back-to-back -> sum_valid=1 one cycle after the 4th transfer, sum_out=30, sat=0.
REQ-034 The bench SHALL check this case: N_SAMPLES=2, ACC_W=8, samples 200 then 100 -> sum_out=255, sat=1, sum_valid=1.
REQ-035 The bench SHALL check this case: N_SAMPLES=3, sq_valid toggling 1,0,1,0,1 with values 49,x,64,x,36 -> sum_out=149 with exactly 3 transfers counted.
REQ-036 The bench SHALL check this case: in DONE, sum_ready held 0 for 5 cycles then 1 -> sum_out stable for all 5 cycles, then IDLE and busy=0 on the next cycle.
REQ-037 The bench SHALL check this case: abort and sq_valid asserted together after 2 of 4 samples -> IDLE next cycle, sum_out=0, sum_valid never 1; a following run of 4×1 -> sum_out=4.
REQ-038 The bench SHALL check this case: rst_n pulsed low mid-run, and separately with SQ_ACCUM_MAX_EN defined a run of 9,81,25 -> all outputs 0 during reset; max_out=81 in DONE.
